pipe_ctrl: RTL and testbench

Parametrised pipeline control unit for the Risc-V-FPGA core. It generalises the fixed F/D/E/M hazard controller to an `NSTAGES`-deep pipeline and produces per-stage stall and flush vectors from the usual hazard inputs. It adds a sequential debug-halt drain with acknowledge handshake and a one-cycle trap-entry sequence. It sits beside the datapath and drives every pipeline register's hold/bubble controls.

---
 rtl/pipe_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller with debug-halt drain and trap entry.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_ctrl #(
    parameter int unsigned NSTAGES  = 5,
    parameter int unsigned EX_STAGE = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               data_hazard_i,
    input  logic               d_is_privileged_i,
    input  logic               em_is_csr_write_i,
    input  logic               alu_busy_i,
    input  logic               e_correct_pc_i,
    input  logic               trap_req_i,
    input  logic               halt_req_i,
    output logic [NSTAGES-1:0] stall_o,
    output logic [NSTAGES-1:0] flush_o,
    output logic               halt_ack_o,
    output logic               trap_enter_o,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   stall_cycles_o,
    output logic [CNT_W-1:0]   flush_cycles_o
);

    localparam int unsigned DCNT_W = $clog2(NSTAGES);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_TRAP   = 2'd3;

    // Contiguous stage mask covering stages lo..hi inclusive.
    function automatic logic [NSTAGES-1:0] range_mask(input int unsigned lo, input int unsigned hi);
        logic [NSTAGES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NSTAGES; i++) begin
            if (i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NSTAGES-1:0] BUSY_STALL  = range_mask(0, EX_STAGE);
    localparam logic [NSTAGES-1:0] BUSY_FLUSH  = range_mask(EX_STAGE + 1, EX_STAGE + 1);
    localparam logic [NSTAGES-1:0] REDIR_FLUSH = range_mask(1, EX_STAGE);
    localparam logic [NSTAGES-1:0] HZ_STALL    = range_mask(0, 1);
    localparam logic [NSTAGES-1:0] HZ_FLUSH    = range_mask(2, 2);
    localparam logic [NSTAGES-1:0] FE_STALL    = range_mask(0, 0);
    localparam logic [NSTAGES-1:0] DEC_FLUSH   = range_mask(1, 1);
    localparam logic [NSTAGES-1:0] TRAP_FLUSH  = range_mask(1, NSTAGES - 2);

    logic [1:0]        state_q, state_nx;
    logic [DCNT_W-1:0] dcnt_q, dcnt_nx;
    logic              csr_hz;

    assign csr_hz  = d_is_privileged_i & em_is_csr_write_i;
    assign state_o = state_q;

    // Next state plus combinational stall/flush generation.
    always_comb begin
        state_nx     = state_q;
        dcnt_nx      = dcnt_q;
        stall_o      = '0;
        flush_o      = '0;
        halt_ack_o   = 1'b0;
        trap_enter_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (alu_busy_i) begin
                    stall_o = BUSY_STALL;
                    flush_o = BUSY_FLUSH;
                end else if (e_correct_pc_i) begin
                    flush_o = REDIR_FLUSH;
                end else if (csr_hz || data_hazard_i) begin
                    stall_o = HZ_STALL;
                    flush_o = HZ_FLUSH;
                end
                if (trap_req_i && !alu_busy_i) begin
                    state_nx = ST_TRAP;
                end else if (halt_req_i) begin
                    state_nx = ST_DRAIN;
                    dcnt_nx  = DCNT_W'(NSTAGES - 1);
                end
            end
            ST_DRAIN: begin
                stall_o = FE_STALL;
                flush_o = DEC_FLUSH;
                if (alu_busy_i) begin
                    stall_o = stall_o | BUSY_STALL;
                    flush_o = flush_o | BUSY_FLUSH;
                end else begin
                    if (e_correct_pc_i) flush_o = flush_o | REDIR_FLUSH;
                    dcnt_nx = dcnt_q - DCNT_W'(1);
                    if (trap_req_i) begin
                        state_nx = ST_TRAP;
                    end else if (dcnt_q == DCNT_W'(1)) begin
                        state_nx = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                stall_o    = FE_STALL;
                flush_o    = DEC_FLUSH;
                halt_ack_o = 1'b1;
                if (!halt_req_i) state_nx = ST_RUN;
            end
            default: begin
                trap_enter_o = 1'b1;
                flush_o      = TRAP_FLUSH;
                state_nx     = ST_RUN;
            end
        endcase
        // Reset forces a full bubble regardless of state.
        if (reset_i) begin
            stall_o      = '0;
            flush_o      = '1;
            halt_ack_o   = 1'b0;
            trap_enter_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_nx;
            dcnt_q  <= dcnt_nx;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc, flush_inc;

    assign stall_inc = (state_q == ST_RUN) && stall_o[0] && !reset_i;
    assign flush_inc = (state_q == ST_TRAP) ||
                       ((state_q == ST_RUN || state_q == ST_DRAIN) && e_correct_pc_i && !alu_busy_i);

    // Free-running wrap-around event counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_inc) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_cycles_o = flush_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign flush_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: vector table, hand-written multi-cycle sequences,
// and randomized traffic checked against a behavioural model.
module tb_pipe_ctrl;
    localparam int unsigned NS = 5;
    localparam int unsigned EX = 2;
    localparam int unsigned CW = 32;

    typedef struct packed {
        logic rst, dh, priv, csrw, busy, cpc, trap, halt;
    } in_t;

    typedef struct packed {
        logic [NS-1:0] stall;
        logic [NS-1:0] flush;
        logic          ack;
        logic          te;
        logic [1:0]    st;
    } exp_t;

    typedef struct {
        in_t  v;
        exp_t e;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_i, data_hazard_i, d_is_privileged_i, em_is_csr_write_i;
    logic          alu_busy_i, e_correct_pc_i, trap_req_i, halt_req_i;
    logic [NS-1:0] stall_o, flush_o;
    logic          halt_ack_o, trap_enter_o;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cycles_o, flush_cycles_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.NSTAGES(NS), .EX_STAGE(EX), .CNT_W(CW)) dut (
        .clk_i(clk), .reset_i(reset_i), .data_hazard_i(data_hazard_i),
        .d_is_privileged_i(d_is_privileged_i), .em_is_csr_write_i(em_is_csr_write_i),
        .alu_busy_i(alu_busy_i), .e_correct_pc_i(e_correct_pc_i),
        .trap_req_i(trap_req_i), .halt_req_i(halt_req_i),
        .stall_o(stall_o), .flush_o(flush_o), .halt_ack_o(halt_ack_o),
        .trap_enter_o(trap_enter_o), .state_o(state_o),
        .stall_cycles_o(stall_cycles_o), .flush_cycles_o(flush_cycles_o)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Model state: mode 0 run, 1 drain, 2 halted, 3 trap; left = drain cycles still owed.
    int md = 0;
    int left = 0;
    logic [CW-1:0] m_sc = '0;
    logic [CW-1:0] m_fc = '0;

    function automatic logic [NS-1:0] span(input int lo, input int hi);
        int v;
        v = ((1 << (hi + 1)) - 1) ^ ((1 << lo) - 1);
        return NS'(v);
    endfunction

    function automatic exp_t ex(input logic [NS-1:0] s, input logic [NS-1:0] f,
                                input logic a, input logic t, input logic [1:0] st);
        exp_t r;
        r.stall = s; r.flush = f; r.ack = a; r.te = t; r.st = st;
        return r;
    endfunction

    function automatic exp_t model_out(input in_t v);
        exp_t r;
        logic hz;
        r = '0;
        r.st = 2'(md);
        hz = (v.priv & v.csrw) | v.dh;
        if (md == 0 || md == 1) begin
            if (v.busy) begin
                r.stall = span(0, EX);
                r.flush = span(EX + 1, EX + 1);
            end else if (v.cpc) begin
                r.flush = span(1, EX);
            end else if (md == 0 && hz) begin
                r.stall = span(0, 1);
                r.flush = span(2, 2);
            end
        end
        if (md == 1 || md == 2) begin
            r.stall = r.stall | span(0, 0);
            r.flush = r.flush | span(1, 1);
        end
        if (md == 2) r.ack = 1'b1;
        if (md == 3) begin
            r.te = 1'b1;
            r.flush = span(1, NS - 2);
        end
        if (v.rst) begin
            r.stall = '0; r.flush = '1; r.ack = 1'b0; r.te = 1'b0;
        end
        return r;
    endfunction

    function automatic void model_step(input in_t v);
        if (v.rst) begin
            md = 0; left = 0; m_sc = '0; m_fc = '0;
            return;
        end
`ifdef PIPE_PERF_CNT_EN
        begin
            exp_t o;
            o = model_out(v);
            if (md == 0 && o.stall[0]) m_sc = m_sc + CW'(1);
            if (md == 3 || (md <= 1 && v.cpc && !v.busy)) m_fc = m_fc + CW'(1);
        end
`endif
        case (md)
            0: begin
                if (v.trap && !v.busy) md = 3;
                else if (v.halt) begin md = 1; left = NS - 1; end
            end
            1: begin
                if (v.trap && !v.busy) md = 3;
                else if (!v.busy) begin
                    left = left - 1;
                    if (left == 0) md = 2;
                end
            end
            2: if (!v.halt) md = 0;
            default: md = 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    endtask

    // One clock cycle: drive, compare mid-cycle, advance model after the edge.
    task automatic step(input in_t v, input exp_t e, input bit use_model, input string tag);
        exp_t x;
        {reset_i, data_hazard_i, d_is_privileged_i, em_is_csr_write_i,
         alu_busy_i, e_correct_pc_i, trap_req_i, halt_req_i} = v;
        @(negedge clk);
        x = use_model ? model_out(v) : e;
        chk({tag, " stall"}, 64'(stall_o), 64'(x.stall));
        chk({tag, " flush"}, 64'(flush_o), 64'(x.flush));
        chk({tag, " ack"}, 64'(halt_ack_o), 64'(x.ack));
        chk({tag, " trap_enter"}, 64'(trap_enter_o), 64'(x.te));
        if (!v.rst) chk({tag, " state"}, 64'(state_o), 64'(x.st));
        if (use_model) begin
            chk({tag, " stall_cnt"}, 64'(stall_cycles_o), 64'(m_sc));
            chk({tag, " flush_cnt"}, 64'(flush_cycles_o), 64'(m_fc));
        end
        @(posedge clk);
        #1;
        model_step(v);
        cyc++;
    endtask

    localparam in_t I_IDLE  = 8'b0000_0000;
    localparam in_t I_HALT  = 8'b0000_0001;
    localparam in_t I_BUSY  = 8'b0000_1000;
    localparam in_t I_BCPC  = 8'b0000_1100;
    localparam in_t I_CPC   = 8'b0000_0100;
    localparam in_t I_BHALT = 8'b0000_1001;
    localparam in_t I_THALT = 8'b0000_0011;
    localparam in_t I_RHALT = 8'b1000_0001;

    vec_t tbl[13];
    logic h;
    in_t  r;

    initial begin
        // Single-cycle RUN-state priority table (NS=5, EX=2).
        tbl[0]  = '{in_t'(8'b1000_0000), ex(5'b00000, 5'b11111, 1'b0, 1'b0, 2'd0)};
        tbl[1]  = '{in_t'(8'b0000_0000), ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0)};
        tbl[2]  = '{in_t'(8'b0100_0000), ex(5'b00011, 5'b00100, 1'b0, 1'b0, 2'd0)};
        tbl[3]  = '{in_t'(8'b0010_0000), ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0)};
        tbl[4]  = '{in_t'(8'b0011_0000), ex(5'b00011, 5'b00100, 1'b0, 1'b0, 2'd0)};
        tbl[5]  = '{in_t'(8'b0001_0000), ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0)};
        tbl[6]  = '{in_t'(8'b0000_0100), ex(5'b00000, 5'b00110, 1'b0, 1'b0, 2'd0)};
        tbl[7]  = '{in_t'(8'b0100_0100), ex(5'b00000, 5'b00110, 1'b0, 1'b0, 2'd0)};
        tbl[8]  = '{in_t'(8'b0000_1000), ex(5'b00111, 5'b01000, 1'b0, 1'b0, 2'd0)};
        tbl[9]  = '{in_t'(8'b0100_1100), ex(5'b00111, 5'b01000, 1'b0, 1'b0, 2'd0)};
        tbl[10] = '{in_t'(8'b0000_1010), ex(5'b00111, 5'b01000, 1'b0, 1'b0, 2'd0)};
        tbl[11] = '{in_t'(8'b0000_0000), ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0)};
        tbl[12] = '{in_t'(8'b1100_0000), ex(5'b00000, 5'b11111, 1'b0, 1'b0, 2'd0)};

        #1;
        for (int i = 0; i < 13; i++) step(tbl[i].v, tbl[i].e, 1'b0, "tbl");

        // Busy for three cycles with a redirect arriving mid-busy.
        step(I_BUSY, ex(5'b00111, 5'b01000, 1'b0, 1'b0, 2'd0), 1'b0, "busy1");
        step(I_BCPC, ex(5'b00111, 5'b01000, 1'b0, 1'b0, 2'd0), 1'b0, "busy2");
        step(I_BUSY, ex(5'b00111, 5'b01000, 1'b0, 1'b0, 2'd0), 1'b0, "busy3");
        step(I_CPC,  ex(5'b00000, 5'b00110, 1'b0, 1'b0, 2'd0), 1'b0, "redir");
        step(I_IDLE, ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0), 1'b0, "idle");

        // Plain halt: drain cycles 1..4, ack from 5, release at 7.
        step(I_HALT, ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0), 1'b0, "halt0");
        for (int i = 0; i < 4; i++) step(I_HALT, ex(5'b00001, 5'b00010, 1'b0, 1'b0, 2'd1), 1'b0, "drain");
        for (int i = 0; i < 2; i++) step(I_HALT, ex(5'b00001, 5'b00010, 1'b1, 1'b0, 2'd2), 1'b0, "halted");
        step(I_IDLE, ex(5'b00001, 5'b00010, 1'b1, 1'b0, 2'd2), 1'b0, "release");
        step(I_IDLE, ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0), 1'b0, "resume");

        // Drain stretched by two busy cycles: ack first in cycle 7.
        step(I_HALT,  ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0), 1'b0, "bhalt0");
        step(I_HALT,  ex(5'b00001, 5'b00010, 1'b0, 1'b0, 2'd1), 1'b0, "bdrain1");
        step(I_BHALT, ex(5'b00111, 5'b01010, 1'b0, 1'b0, 2'd1), 1'b0, "bdrain2");
        step(I_BHALT, ex(5'b00111, 5'b01010, 1'b0, 1'b0, 2'd1), 1'b0, "bdrain3");
        for (int i = 0; i < 3; i++) step(I_HALT, ex(5'b00001, 5'b00010, 1'b0, 1'b0, 2'd1), 1'b0, "bdrain");
        step(I_IDLE, ex(5'b00001, 5'b00010, 1'b1, 1'b0, 2'd2), 1'b0, "bhalted");
        step(I_IDLE, ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0), 1'b0, "bresume");

        // Trap beats halt, then halt re-enters drain; reset mid-drain.
        step(I_THALT, ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0), 1'b0, "trap0");
        step(I_HALT,  ex(5'b00000, 5'b01110, 1'b0, 1'b1, 2'd3), 1'b0, "trap1");
        step(I_HALT,  ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0), 1'b0, "trap2");
        step(I_HALT,  ex(5'b00001, 5'b00010, 1'b0, 1'b0, 2'd1), 1'b0, "trap3");
        step(I_RHALT, ex(5'b00000, 5'b11111, 1'b0, 1'b0, 2'd0), 1'b0, "rst_drain");
        chk("rst stall_cnt", 64'(stall_cycles_o), 64'd0);
        chk("rst flush_cnt", 64'(flush_cycles_o), 64'd0);
        step(I_IDLE, ex(5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0), 1'b0, "post_rst");

        // Randomized traffic against the behavioural model.
        h = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) h = ~h;
            r.rst  = ($urandom_range(0, 79) == 0);
            r.dh   = ($urandom_range(0, 3) == 0);
            r.priv = ($urandom_range(0, 1) == 0);
            r.csrw = ($urandom_range(0, 2) == 0);
            r.busy = ($urandom_range(0, 3) == 0);
            r.cpc  = ($urandom_range(0, 5) == 0);
            r.trap = ($urandom_range(0, 11) == 0);
            r.halt = h;
            step(r, '0, 1'b1, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
